// File: rtl/smc_apb_lite_master30_if.sv
// smc_apb_lite_master30_if: host request/response and APB bus signals of the SMC register master.
interface smc_apb_lite_master30_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid30;
    logic              req_ready30;
    logic              req_write30;
    logic [ADDR_W-1:0] req_addr30;
    logic [DATA_W-1:0] req_wdata30;
    logic              rsp_valid30;
    logic [DATA_W-1:0] rsp_rdata30;
    logic              rsp_err30;
    logic              psel30;
    logic              penable30;
    logic              pwrite30;
    logic [ADDR_W-1:0] paddr30;
    logic [DATA_W-1:0] pwdata30;
    logic [DATA_W-1:0] prdata30;
    logic              pready30;

    modport master (
        input  req_valid30, req_write30, req_addr30, req_wdata30, prdata30, pready30,
        output req_ready30, rsp_valid30, rsp_rdata30, rsp_err30,
        output psel30, penable30, pwrite30, paddr30, pwdata30
    );

    modport slave (
        output req_valid30, req_write30, req_addr30, req_wdata30, prdata30, pready30,
        input  req_ready30, rsp_valid30, rsp_rdata30, rsp_err30,
        input  psel30, penable30, pwrite30, paddr30, pwdata30
    );
endinterface

// File: rtl/smc_apb_lite_master30.sv
// smc_apb_lite_master30: valid/ready host requests to APB setup/access transfers with a wait-state timeout.
module smc_apb_lite_master30 #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   pclk30,
    input  logic                   preset30,
    smc_apb_lite_master30_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       done;
    logic       timeout;
    logic       accept;

    assign done    = state == ACCESS && bus.pready30;
    assign timeout = state == ACCESS && !bus.pready30 && cnt == 8'(TIMEOUT_CYCLES - 1);
    assign bus.req_ready30 = !preset30 && (state == IDLE || done);
    assign accept  = bus.req_valid30 && bus.req_ready30;

    always_ff @(posedge pclk30) begin
        if (preset30) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.psel30      <= 1'b0;
            bus.penable30   <= 1'b0;
            bus.pwrite30    <= 1'b0;
            bus.paddr30     <= {ADDR_W{1'b0}};
            bus.pwdata30    <= {DATA_W{1'b0}};
            bus.rsp_valid30 <= 1'b0;
            bus.rsp_err30   <= 1'b0;
            bus.rsp_rdata30 <= {DATA_W{1'b0}};
        end else begin
            bus.rsp_valid30 <= done;
            bus.rsp_err30   <= 1'b0;
            if (done)
                bus.rsp_rdata30 <= bus.pwrite30 ? {DATA_W{1'b0}} : bus.prdata30;
            // a completion and a new accept can share a cycle: respond and relaunch together
            if (accept) begin
                state         <= SETUP;
                cnt           <= '0;
                bus.psel30    <= 1'b1;
                bus.penable30 <= 1'b0;
                bus.pwrite30  <= bus.req_write30;
                bus.paddr30   <= bus.req_addr30;
                bus.pwdata30  <= bus.req_write30 ? bus.req_wdata30 : {DATA_W{1'b0}};
            end else if (state == SETUP) begin
                state         <= ACCESS;
                bus.penable30 <= 1'b1;
            end else if (done || timeout) begin
                state         <= IDLE;
                bus.psel30    <= 1'b0;
                bus.penable30 <= 1'b0;
                if (timeout) begin
                    bus.rsp_valid30 <= 1'b1;
                    bus.rsp_err30   <= 1'b1;
                    bus.rsp_rdata30 <= {DATA_W{1'b0}};
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_smc_apb_lite_master30.sv
// tb_smc_apb_lite_master30: directed scenarios with a response scoreboard checking data, error flag and latency.
module tb_smc_apb_lite_master30;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    smc_apb_lite_master30_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    smc_apb_lite_master30 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk30  (clk),
        .preset30(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc_n       = 0;
    bit          acc;
    logic        nxt_err;
    logic [31:0] nxt_rdata;
    int          nxt_lat;
    exp_t        q[$];
    int          acc_cyc[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic e, input logic [31:0] r, input int lat);
        bus.req_valid30 = 1'b1;
        bus.req_write30 = w;
        bus.req_addr30  = a;
        bus.req_wdata30 = d;
        nxt_err   = e;
        nxt_rdata = r;
        nxt_lat   = lat;
    endtask

    // one clock: note an accept, advance, then score any response
    task automatic tick();
        exp_t e;
        #1;
        acc = bus.req_valid30 && bus.req_ready30;
        if (acc) q.push_back('{nxt_err, nxt_rdata, cyc_n + nxt_lat});
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (bus.rsp_valid30) begin
            if (q.size() == 0) chk("rsp_spurious", {31'b0, bus.rsp_valid30}, 32'd0);
            else begin
                e = q.pop_front();
                chk("rsp_err", {31'b0, bus.rsp_err30}, {31'b0, e.err});
                chk("rsp_rdata", bus.rsp_rdata30, e.rdata);
                chk("rsp_cycle", cyc_n, e.cyc);
            end
        end
    endtask

    task automatic chk_apb(input string tag, input logic s, input logic en, input logic w,
                           input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_psel"}, {31'b0, bus.psel30}, {31'b0, s});
        chk({tag, "_penable"}, {31'b0, bus.penable30}, {31'b0, en});
        chk({tag, "_pwrite"}, {31'b0, bus.pwrite30}, {31'b0, w});
        chk({tag, "_paddr"}, {27'b0, bus.paddr30}, {27'b0, a});
        chk({tag, "_pwdata"}, bus.pwdata30, d);
    endtask

    task automatic chk_reset(input string tag);
        chk_apb(tag, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
        chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid30}, 32'd0);
        chk({tag, "_rsp_err"}, {31'b0, bus.rsp_err30}, 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata30, 32'h0);
        chk({tag, "_req_ready"}, {31'b0, bus.req_ready30}, 32'd0);
    endtask

    initial begin
        bus.req_valid30 = 1'b0;
        bus.req_write30 = 1'b0;
        bus.req_addr30  = '0;
        bus.req_wdata30 = '0;
        bus.prdata30    = '0;
        bus.pready30    = 1'b1;
        nxt_err   = 1'b0;
        nxt_rdata = '0;
        nxt_lat   = 3;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'b0, bus.req_ready30}, 32'd1);

        // zero-wait write
        req(1'b1, 5'h00, 32'hA5A5_0001, 1'b0, 32'h0, 3);
        tick();
        bus.req_valid30 = 1'b0;
        chk_apb("wr_setup", 1'b1, 1'b0, 1'b1, 5'h00, 32'hA5A5_0001);
        chk("wr_setup_ready", {31'b0, bus.req_ready30}, 32'd0);
        tick();
        chk_apb("wr_access", 1'b1, 1'b1, 1'b1, 5'h00, 32'hA5A5_0001);
        tick();
        chk("wr_idle_psel", {31'b0, bus.psel30}, 32'd0);
        tick();

        // read with data
        bus.prdata30 = 32'h1234_5678;
        req(1'b0, 5'h04, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 3);
        tick();
        bus.req_valid30 = 1'b0;
        chk_apb("rd_setup", 1'b1, 1'b0, 1'b0, 5'h04, 32'h0);
        tick();
        chk_apb("rd_access", 1'b1, 1'b1, 1'b0, 5'h04, 32'h0);
        tick();
        chk("rd_idle_pwrite", {31'b0, bus.pwrite30}, 32'd0);
        tick();

        // three wait states; ready arrives exactly at the timeout limit
        req(1'b1, 5'h03, 32'hDEAD_BEEF, 1'b0, 32'h0, 6);
        tick();
        bus.req_valid30 = 1'b0;
        bus.pready30    = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_apb("wait_hold", 1'b1, 1'b1, 1'b1, 5'h03, 32'hDEAD_BEEF);
            if (i == 3) bus.pready30 = 1'b1;
            #1;
            chk("wait_ready", {31'b0, bus.req_ready30}, {31'b0, (i == 3)});
            tick();
        end
        chk("pending_wait", q.size(), 32'd0);
        tick();

        // timeout, with the next request held pending
        bus.pready30 = 1'b0;
        bus.prdata30 = 32'hFFFF_0000;
        req(1'b0, 5'h07, 32'h0, 1'b1, 32'h0, 6);
        tick();
        req(1'b1, 5'h09, 32'h0BAD_F00D, 1'b0, 32'h0, 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_apb("to_access", 1'b1, 1'b1, 1'b0, 5'h07, 32'h0);
            chk("to_ready", {31'b0, bus.req_ready30}, 32'd0);
            tick();
        end
        chk("to_psel", {31'b0, bus.psel30}, 32'd0);
        chk("to_penable", {31'b0, bus.penable30}, 32'd0);
        chk("pending_to", q.size(), 32'd0);
        bus.pready30 = 1'b1;
        tick();
        bus.req_valid30 = 1'b0;
        chk_apb("after_to_setup", 1'b1, 1'b0, 1'b1, 5'h09, 32'h0BAD_F00D);
        tick();
        tick();
        chk("pending_after_to", q.size(), 32'd0);
        tick();

        // back-to-back writes
        begin
            int k = 0;
            int guard = 0;
            req(1'b1, 5'h10, 32'h0000_0010, 1'b0, 32'h0, 3);
            while (k < 3 && guard < 20) begin
                guard++;
                tick();
                if (acc) begin
                    acc_cyc[k] = cyc_n - 1;
                    k++;
                    if (k < 3) req(1'b1, 5'(5'h10 + k), 32'h0000_0010 + k, 1'b0, 32'h0, 3);
                    else bus.req_valid30 = 1'b0;
                end
                if (k > 0) chk("b2b_psel", {31'b0, bus.psel30}, 32'd1);
            end
            chk("b2b_accepts", k, 32'd3);
            chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd2);
            chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd2);
            for (int i = 0; i < 8 && q.size() > 0; i++) tick();
            chk("pending_b2b", q.size(), 32'd0);
        end
        tick();

        // reset in the middle of an access
        bus.pready30 = 1'b0;
        req(1'b1, 5'h02, 32'h0000_1234, 1'b0, 32'h0, 3);
        tick();
        bus.req_valid30 = 1'b0;
        tick();
        tick();
        chk("mid_in_access", {31'b0, bus.penable30}, 32'd1);
        rst = 1'b1;
        tick();
        chk_reset("mid_reset");
        q.delete();
        rst = 1'b0;
        bus.pready30 = 1'b1;
        tick();
        chk("mid_no_rsp", {31'b0, bus.rsp_valid30}, 32'd0);
        bus.prdata30 = 32'hCAFE_F00D;
        req(1'b0, 5'h01, 32'h0, 1'b0, 32'hCAFE_F00D, 3);
        tick();
        bus.req_valid30 = 1'b0;
        tick();
        tick();
        chk("pending_final", q.size(), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/smc_apb_lite_master30.md
Name: smc_apb_lite_master30

Overview:
- APB initiator driving the SMC register interface: psel30, penable30, pwrite30, paddr30, pwdata30; captures prdata30.
- Converts a simple valid/ready request from the host-side configuration sequencer into APB setup/access phases, then returns a one-cycle response pulse.
- Supports optional responder wait states via pready30, tied high for zero-wait responders.
- Bounds wait states with a timeout counter.

Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready30 low before the transfer is aborted; legal range 1..255.

Ports:
- pclk30  input  1  APB clock; every flop is on its rising edge.
- preset30  input  1  synchronous, active-high reset.
- req_valid30  input  1  host request valid.
- req_ready30  output  1  request accepted when req_valid30 and req_ready30 are both high.
- req_write30  input  1  1 = write, 0 = read.
- req_addr30  input  ADDR_W  request address.
- req_wdata30  input  DATA_W  write data.
- rsp_valid30  output  1  one-cycle response pulse.
- rsp_rdata30  output  DATA_W  read data; valid with rsp_valid30.
- rsp_err30  output  1  timeout abort flag; valid with rsp_valid30.
- psel30  output  1  APB select.
- penable30  output  1  APB enable.
- pwrite30  output  1  APB write strobe.
- paddr30  output  ADDR_W  APB address.
- pwdata30  output  DATA_W  APB write data.
- prdata30  input  DATA_W  APB read data.
- pready30  input  1  responder ready; tie to 1 if unused.

Behaviour:
- One clock, pclk30. Reset is synchronous and active-high on preset30.
- Reset values:
  - state = IDLE.
  - psel30, penable30, pwrite30, rsp_valid30, rsp_err30 = 0.
  - paddr30, pwdata30, rsp_rdata30 = 0.
  - Timeout counter = 0.
- All APB and response outputs are registered.
- req_ready30 is combinational: 1 in IDLE, or in ACCESS when pready30 = 1 and no timeout is firing. It is 0 otherwise and 0 during reset.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: on accept, latch pwrite30, paddr30, pwdata30 (pwdata30 is 0 for reads); next state SETUP.
  - SETUP: psel30 = 1, penable30 = 0; unconditionally next state ACCESS.
  - ACCESS: psel30 = 1, penable30 = 1.
  - ACCESS with pready30 = 1 (completion): next cycle rsp_valid30 = 1, rsp_err30 = 0, rsp_rdata30 = prdata30 sampled this cycle for reads, 0 for writes.
  - After completion: if a new request is accepted in the same cycle, go to SETUP with the new fields latched (back-to-back). Otherwise go to IDLE with psel30 = 0, penable30 = 0.
- Latency: request accepted at cycle N; SETUP at N+1; ACCESS at N+2; with zero waits rsp_valid30 at N+3. Zero-wait throughput is one transfer per 2 cycles.
- Wait states:
  - While in ACCESS with pready30 = 0, hold psel30, penable30, paddr30, pwrite30 and pwdata30 stable, and increment the counter.
  - The counter clears on entry to SETUP.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES - 1 and pready30 is still 0, abort.
  - Abort: next cycle rsp_valid30 = 1, rsp_err30 = 1, rsp_rdata30 = 0; psel30 and penable30 drop; state goes to IDLE.
  - No request is accepted in the abort cycle.
  - pready30 = 1 in the same cycle the limit is reached counts as normal completion, not timeout.
- rsp_valid30 is high for exactly one cycle per accepted request. There is no backpressure on the response; the host must consume it.
- Request fields are ignored while req_ready30 = 0. Held requests are not lost; they are accepted when req_ready30 rises.
- preset30 asserted mid-transfer: the next edge forces reset values, drops psel30 and penable30, and drops the in-flight transfer without generating a response.
- paddr30 and pwdata30 keep their last values in IDLE; only psel30 qualifies them.

Test Plan:
- Zero-wait write: reset, pready30 = 1, request write addr 5'h00 data 32'hA5A5_0001 -> SETUP cycle has psel30 = 1, penable30 = 0; ACCESS cycle has penable30 = 1, pwrite30 = 1, paddr30 = 0, pwdata30 = 32'hA5A5_0001; rsp_valid30 = 1 and rsp_err30 = 0 at accept + 3.
- Read with data: prdata30 = 32'h1234_5678, read addr 5'h04 -> rsp_rdata30 = 32'h1234_5678 with rsp_valid30 at accept + 3; pwrite30 = 0 throughout.
- Wait states: pready30 low for 3 ACCESS cycles, then high -> APB signals stable across all 4 ACCESS cycles; rsp_valid30 at accept + 6, rsp_err30 = 0.
- Timeout: TIMEOUT_CYCLES = 4, pready30 held 0 -> exactly 4 ACCESS cycles; then rsp_valid30 = 1, rsp_err30 = 1, rsp_rdata30 = 0, psel30 = 0; next request accepted normally.
- Back-to-back: req_valid30 held high with 3 queued writes, pready30 = 1 -> SETUP/ACCESS pairs with no IDLE gap; 3 rsp_valid30 pulses spaced 2 cycles apart.
- Mid-transfer reset: assert preset30 during ACCESS -> next cycle all outputs at reset values; no rsp_valid30 pulse; first request after deassertion completes normally.
